// File: rtl/synth_decode_7.sv
// Recovers b from core-7 results: buffers (a, c, sel) keys in a FIFO, pairs each result with its key in order,
// and emits b = res ^ (m + a + m) through a 2-stage valid/ready pipeline. Optional checker: SYNTH_DECODE_CHECK_EN.
module synth_decode_7 #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_valid,
    output logic                   key_ready,
    input  logic [W-1:0]           key_a,
    input  logic [W-1:0]           key_c,
    input  logic                   key_sel,
`ifdef SYNTH_DECODE_CHECK_EN
    input  logic [W-1:0]           key_exp_b,
    output logic                   chk_err,
    output logic [15:0]            chk_err_cnt,
`endif
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [W-1:0]           res_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_b,
    output logic [$clog2(DEPTH):0] key_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Key FIFO storage and control
    logic [W-1:0]  fifo_a   [DEPTH];
    logic [W-1:0]  fifo_c   [DEPTH];
    logic          fifo_sel [DEPTH];
`ifdef SYNTH_DECODE_CHECK_EN
    logic [W-1:0]  fifo_exp [DEPTH];
`endif
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          key_fire;
    logic          res_fire;

    // Pipeline state
    logic          s1_valid;
    logic [W-1:0]  s1_res;
    logic [W-1:0]  s1_a;
    logic [W-1:0]  s1_c;
    logic          s1_sel;
    logic          s2_valid;
    logic          s2_accept;
    logic          s1_advance;
    logic [W-1:0]  s1_m;
    logic [W-1:0]  s1_mask;
`ifdef SYNTH_DECODE_CHECK_EN
    logic [W-1:0]  s1_exp;
    logic [W-1:0]  s2_exp;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign key_count  = count;

    // key_ready comes only from the occupancy register, so a same-cycle pop cannot free a slot.
    assign key_ready  = !fifo_full;
    assign key_fire   = key_valid && key_ready;

    assign s2_accept  = !s2_valid || out_ready;
    assign s1_advance = !s1_valid || s2_accept;
    assign res_ready  = !fifo_empty && s1_advance;
    assign res_fire   = res_valid && res_ready;
    assign out_valid  = s2_valid;

    // NOTE: storage arrays carry no reset; the pointers and count alone define which entries are live,
    // so resetting the array would only add reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (key_fire) begin
            fifo_a[wr_ptr]   <= key_a;
            fifo_c[wr_ptr]   <= key_c;
            fifo_sel[wr_ptr] <= key_sel;
`ifdef SYNTH_DECODE_CHECK_EN
            fifo_exp[wr_ptr] <= key_exp_b;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (key_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (res_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({key_fire, res_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Stage 1: capture the result together with the head key.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_advance) begin
            s1_valid <= res_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (res_fire) begin
            s1_res <= res_data;
            s1_a   <= fifo_a[rd_ptr];
            s1_c   <= fifo_c[rd_ptr];
            s1_sel <= fifo_sel[rd_ptr];
`ifdef SYNTH_DECODE_CHECK_EN
            s1_exp <= fifo_exp[rd_ptr];
`endif
        end
    end

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        s1_m    = s1_sel ? s1_a : s1_c;
        s1_mask = s1_m + s1_a + s1_m;
    end

    // Stage 2: undo the XOR; out_b is held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_b    <= '0;
        end else if (s2_accept) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_b <= s1_res ^ s1_mask;
            end
        end
    end

`ifdef SYNTH_DECODE_CHECK_EN
    always_ff @(posedge clk) begin
        if (s2_accept && s1_valid) begin
            s2_exp <= s1_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err     <= 1'b0;
            chk_err_cnt <= '0;
        end else if (out_valid && out_ready && (out_b != s2_exp)) begin
            chk_err <= 1'b1;
            if (chk_err_cnt != 16'hFFFF) begin
                chk_err_cnt <= chk_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_synth_decode_7.sv
// Self-checking bench for synth_decode_7: directed cases plus randomized traffic against a queue-based model.
module tb_synth_decode_7;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   key_valid = 1'b0;
    logic                   key_ready;
    logic [W-1:0]           key_a = '0;
    logic [W-1:0]           key_c = '0;
    logic                   key_sel = 1'b0;
    logic [W-1:0]           exp_b_drv = '0;
    logic                   res_valid = 1'b0;
    logic                   res_ready;
    logic [W-1:0]           res_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [W-1:0]           out_b;
    logic [$clog2(DEPTH):0] key_count;
`ifdef SYNTH_DECODE_CHECK_EN
    logic                   chk_err;
    logic [15:0]            chk_err_cnt;
`endif

    always #5 clk = ~clk;

    synth_decode_7 #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_a      (key_a),
        .key_c      (key_c),
        .key_sel    (key_sel),
`ifdef SYNTH_DECODE_CHECK_EN
        .key_exp_b  (exp_b_drv),
        .chk_err    (chk_err),
        .chk_err_cnt(chk_err_cnt),
`endif
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_b      (out_b),
        .key_count  (key_count)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] c;
        logic         sel;
        logic [W-1:0] e;
    } key_t;

    typedef struct {
        logic [W-1:0] b;
        logic [W-1:0] e;
    } out_t;

    key_t kq[$];
    out_t oq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   err_cnt = 0;
    int   fires = 0;
    int   emitted = 0;
    logic stall_prev = 1'b0;
    logic [W-1:0] stall_b = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // b = res ^ ((2*m + a) mod 2^W), m = sel ? a : c
    function automatic logic [W-1:0] ref_b(input key_t k, input logic [W-1:0] r);
        longint unsigned m;
        longint unsigned mask;
        m    = k.sel ? 64'(k.a) : 64'(k.c);
        mask = (2 * m + 64'(k.a)) % (64'd1 << W);
        return r ^ W'(mask);
    endfunction

    // One clock: inputs were set at the negedge; sample handshakes, check, advance the model.
    task automatic tick();
        key_t k;
        out_t o;
        #1;
        check("key_count", 64'(key_count), 64'(kq.size()));
        check("key_ready", key_ready, kq.size() < DEPTH);
        if (kq.size() == 0) check("res_ready_empty", res_ready, 1'b0);
        if (out_valid) check("out_valid_has_data", oq.size() != 0, 1'b1);
        if (stall_prev) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_out_b", out_b, stall_b);
        end
`ifdef SYNTH_DECODE_CHECK_EN
        check("chk_err", chk_err, err_cnt != 0);
        check("chk_err_cnt", chk_err_cnt, 64'(err_cnt));
`endif
        if (rst) begin
            kq.delete();
            oq.delete();
            err_cnt    = 0;
            stall_prev = 1'b0;
        end else begin
            if (out_valid && out_ready && oq.size() != 0) begin
                o = oq.pop_front();
                check("out_b", out_b, o.b);
                if (o.b != o.e && err_cnt < 65535) err_cnt++;
                emitted++;
            end
            stall_prev = out_valid && !out_ready;
            stall_b    = out_b;
            if (res_valid && res_ready) begin
                if (kq.size() == 0) begin
                    check("pop_on_empty", res_ready, 1'b0);
                end else begin
                    k = kq.pop_front();
                    oq.push_back('{b: ref_b(k, res_data), e: k.e});
                    fires++;
                end
            end
            if (key_valid && key_ready) begin
                kq.push_back('{a: key_a, c: key_c, sel: key_sel, e: exp_b_drv});
            end
        end
        @(negedge clk);
    endtask

    // Push one key, fire one result, verify latency and value.
    task automatic pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] c,
                        input logic sel, input logic [W-1:0] e, input logic [W-1:0] r,
                        input logic [W-1:0] want);
        key_valid = 1'b1; key_a = a; key_c = c; key_sel = sel; exp_b_drv = e;
        out_ready = 1'b1;
        tick();
        key_valid = 1'b0;
        res_valid = 1'b1; res_data = r;
        #1;
        check({tag, "_fire"}, res_ready, 1'b1);
        tick();
        res_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 1'b0);
        tick();
        check({tag, "_lat2"}, out_valid, 1'b1);
        check({tag, "_b"}, out_b, want);
        tick();
        check({tag, "_done"}, out_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_emit;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_b", out_b, '0);
        check("rst_key_ready", key_ready, 1'b1);
        check("rst_res_ready", res_ready, 1'b0);
        check("rst_key_count", 64'(key_count), 64'd0);

        pair("basic", 32'h1, 32'h2, 1'b1, 32'h10, 32'h13, 32'h10);
        pair("sel0", 32'h1, 32'h2, 1'b0, 32'hFF, 32'hFA, 32'hFF);
        pair("wrap", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 32'hFFFF_FFFD, 32'h0);

        // Fill the FIFO, offer a fifth key, then stall the output.
        out_ready = 1'b0;
        key_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            key_a = $urandom; key_c = $urandom; key_sel = 1'($urandom); exp_b_drv = $urandom;
            tick();
        end
        key_valid = 1'b0;
        check("full_count", 64'(key_count), 64'd4);
        check("full_ready", key_ready, 1'b0);
        fires = 0;
        start_emit = emitted;
        res_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            res_data = $urandom;
            tick();
        end
        check("stall_accepts", 64'(fires), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (kq.size() != 0 || oq.size() != 0); i++) begin
            res_data = $urandom;
            tick();
        end
        res_valid = 1'b0;
        check("drain_empty", 64'(kq.size() + oq.size()), 64'd0);
        check("drain_emitted", 64'(emitted - start_emit), 64'd4);

        // Result with no key waiting must stall.
        res_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            res_data = $urandom;
            tick();
            check("empty_no_out", out_valid, 1'b0);
        end
        res_valid = 1'b0;

        // Reset with keys queued.
        key_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            key_a = $urandom; key_c = $urandom; key_sel = 1'($urandom);
            tick();
        end
        key_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_count", 64'(key_count), 64'd0);
        check("rst_mid_valid", out_valid, 1'b0);
        res_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mid_quiet", out_valid, 1'b0);
        end
        res_valid = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            key_valid = 1'($urandom);
            key_a = $urandom; key_c = $urandom; key_sel = 1'($urandom); exp_b_drv = $urandom;
            res_valid = 1'($urandom);
            res_data = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        key_valid = 1'b0;
        res_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (kq.size() != 0 || oq.size() != 0); i++) begin
            res_data = $urandom;
            tick();
        end
        res_valid = 1'b0;
        check("rand_drain", 64'(kq.size() + oq.size()), 64'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef SYNTH_DECODE_CHECK_EN
        pair("chk_bad", 32'h1, 32'h2, 1'b1, 32'h10, 32'h12, 32'h11);
        check("chk_bad_err", chk_err, 1'b1);
        check("chk_bad_cnt", chk_err_cnt, 16'd1);
        pair("chk_good", 32'h1, 32'h2, 1'b1, 32'h10, 32'h13, 32'h10);
        check("chk_good_err", chk_err, 1'b1);
        check("chk_good_cnt", chk_err_cnt, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
